// File: rtl/sprite_pkg.sv
// sprite_pkg: state encoding and key indices shared by the player sprite controller.
package sprite_pkg;
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_STAND = 2'd1;
  localparam logic [1:0] ST_JUMP = 2'd2;
  localparam logic [1:0] ST_CROUCH = 2'd3;
  typedef enum logic [1:0] {
    S_RUN = ST_RUN,
    S_STAND = ST_STAND,
    S_JUMP = ST_JUMP,
    S_CROUCH = ST_CROUCH
  } state_t;
  localparam int KEY_JUMP = 0;
  localparam int KEY_CROUCH = 1;
  localparam int KEY_STAND = 2;
endpackage

// File: rtl/player_sprite_ctrl_if.sv
// player_sprite_ctrl_if: frame tick and buttons in, sprite position/id and status out.
interface player_sprite_ctrl_if #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 9,
  parameter int ID_WIDTH = 4
);
  logic update;
  logic [3:0] keys;
  logic [X_WIDTH-1:0] x_sprite;
  logic [Y_WIDTH-1:0] y_sprite;
  logic [ID_WIDTH-1:0] sprite_id;
  logic airborne;
  logic landed;
  modport master (output update, keys, input x_sprite, y_sprite, sprite_id, airborne, landed);
  modport slave (input update, keys, output x_sprite, y_sprite, sprite_id, airborne, landed);
endinterface

// File: rtl/run_animator.sv
// run_animator: divides run steps by ANIM_DIV and cycles the frame index 0..RUN_FRAMES-1.
module run_animator #(
  parameter int ID_WIDTH = 4,
  parameter int RUN_FRAMES = 3,
  parameter int ANIM_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_step,
  input  logic i_hold,
  input  logic i_clear,
  output logic [ID_WIDTH-1:0] o_frame
);
  localparam int DW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  logic [DW-1:0] r_div;
  logic [ID_WIDTH-1:0] r_frame;
  logic w_wrap;
  assign w_wrap = r_div == DW'(ANIM_DIV - 1);
  assign o_frame = r_frame;
  always_ff @(posedge clk)
    if (rst || i_clear) begin
      r_div <= '0;
      r_frame <= '0;
    end else if (i_step && !i_hold) begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap) r_frame <= (r_frame == ID_WIDTH'(RUN_FRAMES - 1)) ? '0 : r_frame + 1'b1;
    end
endmodule

// File: rtl/player_sprite_ctrl.sv
// player_sprite_ctrl: run/stand/jump/crouch sprite FSM advanced on frame ticks.
// Define DOUBLE_JUMP_EN to allow one mid-air relaunch on a jump-key press edge.
module player_sprite_ctrl
  import sprite_pkg::*;
#(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 9,
  parameter int ID_WIDTH = 4,
  parameter int VEL_WIDTH = 8,
  parameter int GROUND_X = 95,
  parameter int Y_POS = 119,
  parameter int JUMP_VEL = 14,
  parameter int GRAVITY = 2,
  parameter int RUN_FRAMES = 3,
  parameter int ANIM_DIV = 1,
  parameter int STAND_ID = 0,
  parameter int JUMP_ID = 3,
  parameter int CROUCH_ID = 4
) (
  input logic clk,
  input logic rst,
  player_sprite_ctrl_if.slave bus
);
  localparam int NW = X_WIDTH + 2;
  localparam logic signed [NW-1:0] GROUND_S = NW'(GROUND_X);
  localparam logic signed [NW-1:0] X_MAX = NW'((1 << X_WIDTH) - 1);
  localparam logic [X_WIDTH-1:0] GROUND = X_WIDTH'(GROUND_X);
  localparam logic signed [VEL_WIDTH-1:0] VEL_LAUNCH = VEL_WIDTH'(JUMP_VEL);
  state_t r_state, w_next;
  logic [X_WIDTH-1:0] r_x;
  logic signed [VEL_WIDTH-1:0] r_vel, w_vel, w_vel_nxt;
  logic signed [VEL_WIDTH:0] w_vel_dec;
  logic signed [NW-1:0] w_sum;
  logic [ID_WIDTH-1:0] r_id, w_frame, w_id;
  logic r_air, r_landed, w_relaunch, w_land, w_clear;
`ifdef DOUBLE_JUMP_EN
  logic r_prev_k0, r_dbl;
  assign w_relaunch = r_state == S_JUMP && !r_dbl && r_prev_k0 && !bus.keys[KEY_JUMP];
  always_ff @(posedge clk)
    if (rst) begin
      r_prev_k0 <= 1'b1;
      r_dbl <= 1'b0;
    end else if (bus.update) begin
      r_prev_k0 <= bus.keys[KEY_JUMP];
      if (w_relaunch) r_dbl <= 1'b1;
      else if (r_state == S_JUMP && w_land) r_dbl <= 1'b0;
    end
`else
  assign w_relaunch = 1'b0;
`endif
  // a relaunch replaces the velocity used for this update, so it can never land
  always_comb begin
    w_vel = w_relaunch ? VEL_LAUNCH : r_vel;
    w_sum = $signed({2'b00, r_x}) + $signed({{(NW - VEL_WIDTH){w_vel[VEL_WIDTH-1]}}, w_vel});
    w_land = w_vel[VEL_WIDTH-1] && w_sum <= GROUND_S;
    w_vel_dec = {w_vel[VEL_WIDTH-1], w_vel} - (VEL_WIDTH + 1)'(GRAVITY);
    w_vel_nxt = (w_vel_dec[VEL_WIDTH] != w_vel_dec[VEL_WIDTH-1]) ? {1'b1, {(VEL_WIDTH - 1){1'b0}}}
                                                                  : w_vel_dec[VEL_WIDTH-1:0];
    case (r_state)
      S_RUN, S_STAND: w_next = !bus.keys[KEY_JUMP] ? S_JUMP : !bus.keys[KEY_CROUCH] ? S_CROUCH :
                               !bus.keys[KEY_STAND] ? S_STAND : S_RUN;
      S_CROUCH: w_next = !bus.keys[KEY_JUMP] ? S_JUMP : bus.keys[KEY_CROUCH] ? S_RUN : S_CROUCH;
      default: w_next = w_land ? S_RUN : S_JUMP;
    endcase
    w_clear = bus.update && w_next == S_RUN && (r_state == S_JUMP || r_state == S_CROUCH);
    w_id = w_next == S_RUN ? (w_clear ? '0 : w_frame) : w_next == S_STAND ? ID_WIDTH'(STAND_ID) :
           w_next == S_JUMP ? ID_WIDTH'(JUMP_ID) : ID_WIDTH'(CROUCH_ID);
  end
  run_animator #(.ID_WIDTH(ID_WIDTH), .RUN_FRAMES(RUN_FRAMES), .ANIM_DIV(ANIM_DIV)) u_anim (
    .clk(clk),
    .rst(rst),
    .i_step(bus.update && r_state == S_RUN),
    .i_hold(w_next == S_STAND),
    .i_clear(w_clear),
    .o_frame(w_frame)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_RUN;
      r_x <= GROUND;
      r_vel <= '0;
      r_id <= '0;
      r_air <= 1'b0;
      r_landed <= 1'b0;
    end else begin
      r_landed <= 1'b0;
      if (bus.update) begin
        r_state <= w_next;
        r_air <= w_next == S_JUMP;
        r_id <= w_id;
        if (r_state == S_JUMP) begin
          r_x <= w_land ? GROUND : (w_sum > X_MAX) ? '1 : w_sum[X_WIDTH-1:0];
          r_vel <= w_land ? '0 : w_vel_nxt;
          r_landed <= w_land;
        end else begin
          r_x <= GROUND;
          r_vel <= w_next == S_JUMP ? VEL_LAUNCH : '0;
        end
      end
    end
  assign bus.x_sprite = r_x;
  assign bus.y_sprite = Y_WIDTH'(Y_POS);
  assign bus.sprite_id = r_id;
  assign bus.airborne = r_air;
  assign bus.landed = r_landed;
endmodule

// File: tb/tb_player_sprite_ctrl.sv
// tb_player_sprite_ctrl: scoreboard bench for two controllers (launch 14 and 100) against a behavioural model.
module tb_player_sprite_ctrl;
  localparam int M_RUN = 0, M_STAND = 1, M_JUMP = 2, M_CROUCH = 3;
`ifdef DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif
  typedef struct {
    int st; int x; int v; int frame; int div; int id;
    bit air; bit landed; bit dbl; bit pk0;
  } mdl_t;
  typedef struct { int x; int id; bit air; bit landed; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0;
  exp_t qa[$], qb[$];
  mdl_t ma, mb;

  always #5 clk = ~clk;

  player_sprite_ctrl_if ifa ();
  player_sprite_ctrl_if ifb ();
  player_sprite_ctrl dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  player_sprite_ctrl #(.JUMP_VEL(100)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  function automatic mdl_t reset_m();
    mdl_t m;
    m.st = M_RUN; m.x = 95; m.v = 0; m.frame = 0; m.div = 0; m.id = 0;
    m.air = 0; m.landed = 0; m.dbl = 0; m.pk0 = 1;
    return m;
  endfunction

  // one clock of the player rules: heights in plain integers, clamped at ground and 255
  function automatic mdl_t step(mdl_t m, bit r, bit u, logic [3:0] k, int jv);
    mdl_t n = m;
    int nx;
    n.landed = 0;
    if (r) return reset_m();
    if (!u) return n;
    n.pk0 = k[0];
    case (m.st)
      M_RUN, M_STAND: begin
        if (!k[0]) begin n.st = M_JUMP; n.v = jv; end
        else if (!k[1]) n.st = M_CROUCH;
        else if (!k[2]) n.st = M_STAND;
        else n.st = M_RUN;
        if (n.st == M_RUN) n.id = m.frame;
        if (m.st == M_RUN && n.st == M_RUN) begin
          n.div = m.div + 1;
          if (n.div == 1) begin n.div = 0; n.frame = (m.frame + 1) % 3; end
        end
      end
      M_CROUCH: begin
        if (!k[0]) begin n.st = M_JUMP; n.v = jv; end
        else if (k[1]) begin n.st = M_RUN; n.frame = 0; n.div = 0; n.id = 0; end
      end
      default: begin
        if (DJ && !m.dbl && m.pk0 && !k[0]) begin n.v = jv; n.dbl = 1; end
        nx = m.x + n.v;
        if (n.v < 0 && nx <= 95) begin
          n.x = 95; n.v = 0; n.landed = 1; n.st = M_RUN;
          n.frame = 0; n.div = 0; n.id = 0; n.dbl = 0;
        end else begin
          n.x = nx > 255 ? 255 : nx;
          n.v = (n.v - 2 < -128) ? -128 : n.v - 2;
        end
      end
    endcase
    n.air = n.st == M_JUMP;
    if (n.st == M_STAND) n.id = 0;
    if (n.st == M_JUMP) n.id = 3;
    if (n.st == M_CROUCH) n.id = 4;
    return n;
  endfunction

  function automatic exp_t to_exp(mdl_t m);
    exp_t e;
    e.x = m.x; e.id = m.id; e.air = m.air; e.landed = m.landed;
    return e;
  endfunction

  task automatic chk(string nm, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic drive(bit r, bit u, logic [3:0] k);
    @(negedge clk);
    rst = r;
    ifa.update = u; ifa.keys = k;
    ifb.update = u; ifb.keys = k;
    ma = step(ma, r, u, k, 14);
    mb = step(mb, r, u, k, 100);
    qa.push_back(to_exp(ma));
    qb.push_back(to_exp(mb));
  endtask

  task automatic upd(logic [3:0] k, int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, k);
      drive(0, 0, 4'hF);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_x", int'(ifa.x_sprite), e.x);
        chk("a_y", int'(ifa.y_sprite), 119);
        chk("a_id", int'(ifa.sprite_id), e.id);
        chk("a_air", int'(ifa.airborne), int'(e.air));
        chk("a_landed", int'(ifa.landed), int'(e.landed));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_x", int'(ifb.x_sprite), e.x);
        chk("b_id", int'(ifb.sprite_id), e.id);
        chk("b_air", int'(ifb.airborne), int'(e.air));
        chk("b_landed", int'(ifb.landed), int'(e.landed));
      end
    end
  end

  initial begin
    ma = reset_m();
    mb = reset_m();
    ifa.update = 0; ifa.keys = 4'hF;
    ifb.update = 0; ifb.keys = 4'hF;
    drive(1, 0, 4'hF);
    drive(1, 0, 4'hF);
    upd(4'hF, 6);
    upd(4'hE, 1);
    upd(4'hF, 20);
    upd(4'hC, 1);
    upd(4'hD, 20);
    upd(4'hF, 4);
    upd(4'hB, 5);
    upd(4'hF, 4);
    upd(4'hE, 1);
    upd(4'hF, 7);
    upd(4'hE, 1);
    upd(4'hF, 2);
    upd(4'hE, 1);
    upd(4'hF, 120);
    upd(4'hE, 1);
    upd(4'hF, 20);
    drive(1, 1, 4'hF);
    upd(4'hF, 3);
    upd(4'hE, 40);
    upd(4'hF, 120);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", qa.size() + qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
